// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - weight preload and skewed activation feeder for a ROWS x COLS systolic array
module systolic_feeder #(
    parameter int ROWS    = 2,
    parameter int COLS    = 2,
    parameter int MAX_VEC = 8,
    localparam int NVW    = $clog2(MAX_VEC + 1),
    localparam int WAW    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int XAW    = (MAX_VEC * ROWS > 1) ? $clog2(MAX_VEC * ROWS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [NVW-1:0]       num_vec_i,
    input  logic                 wbuf_we_i,
    input  logic [WAW-1:0]       wbuf_addr_i,
    input  logic [15:0]          wbuf_data_i,
    input  logic                 xbuf_we_i,
    input  logic [XAW-1:0]       xbuf_addr_i,
    input  logic [15:0]          xbuf_data_i,
    output logic [COLS*16-1:0]   w_out_o,
    output logic [COLS-1:0]      accept_w_out_o,
    output logic [ROWS*16-1:0]   x_out_o,
    output logic [ROWS-1:0]      valid_out_o,
    output logic [ROWS-1:0]      switch_out_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int CW = $clog2(3 * ROWS + COLS + MAX_VEC + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_e;

    logic [15:0]        wbuf_q [ROWS*COLS];
    logic [15:0]        xbuf_q [MAX_VEC*ROWS];

    state_e             state_q, state_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [NVW-1:0]     nv_q, nv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [COLS*16-1:0] w_q, w_d;
    logic [COLS-1:0]    acc_q, acc_d;
    logic [ROWS*16-1:0] x_q, x_d;
    logic [ROWS-1:0]    v_q, v_d;
    logic [ROWS-1:0]    s_q, s_d;
    logic               run;
    int                 n, last_v, done_at, j;

    // Buffers have no reset so their contents survive an aborted run.
    always_ff @(posedge clk_i) begin
        if (wbuf_we_i && !busy_q) wbuf_q[wbuf_addr_i] <= wbuf_data_i;
        if (xbuf_we_i && !busy_q) xbuf_q[xbuf_addr_i] <= xbuf_data_i;
    end

    // cyc_d is the run-relative number of the cycle whose outputs are being registered.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        nv_d    = nv_q;
        run     = 1'b0;
        w_d     = '0;
        acc_d   = '0;
        x_d     = '0;
        v_d     = '0;
        s_d     = '0;
        j       = 0;
        if (state_q == IDLE) begin
            if (start_i && !busy_q && num_vec_i != '0 && num_vec_i <= NVW'(MAX_VEC)) begin
                cyc_d = CW'(1);
                nv_d  = num_vec_i;
                run   = 1'b1;
            end
        end else begin
            cyc_d = cyc_q + CW'(1);
            run   = 1'b1;
        end
        n       = int'(cyc_d);
        last_v  = 2 * ROWS + int'(nv_d) - 1;
        done_at = last_v + ROWS + COLS;
        if (run) begin
            if (n <= ROWS)         state_d = LOAD_W;
            else if (n <= last_v)  state_d = STREAM;
            else if (n < done_at)  state_d = DRAIN;
            else                   state_d = IDLE;
        end
        busy_d = run;
        done_d = run && (n == done_at);
        // Weights go out bottom row first so row 0 ends up in the top PE.
        if (run && n >= 1 && n <= ROWS) begin
            acc_d = '1;
            for (int c = 0; c < COLS; c++)
                w_d[c*16 +: 16] = wbuf_q[WAW'((ROWS - n) * COLS + c)];
        end
        if (run) begin
            for (int r = 0; r < ROWS; r++) begin
                j = n - ROWS - 1 - r;
                if (j >= 0 && j < int'(nv_d)) begin
                    x_d[r*16 +: 16] = xbuf_q[XAW'(j * ROWS + r)];
                    v_d[r]          = 1'b1;
                    s_d[r]          = (j == 0);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            nv_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            w_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            v_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            nv_q    <= nv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            w_q     <= w_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            v_q     <= v_d;
            s_q     <= s_d;
        end
    end

    assign w_out_o        = w_q;
    assign accept_w_out_o = acc_q;
    assign x_out_o        = x_q;
    assign valid_out_o    = v_q;
    assign switch_out_o   = s_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized self-checking bench for systolic_feeder
module tb_systolic_feeder;
    localparam int R   = 2;
    localparam int C   = 2;
    localparam int MV  = 8;
    localparam int NVW = $clog2(MV + 1);
    localparam int WAW = $clog2(R * C);
    localparam int XAW = $clog2(MV * R);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [NVW-1:0]     num_vec = '0;
    logic               wbuf_we = 1'b0;
    logic [WAW-1:0]     wbuf_addr = '0;
    logic [15:0]        wbuf_data = '0;
    logic               xbuf_we = 1'b0;
    logic [XAW-1:0]     xbuf_addr = '0;
    logic [15:0]        xbuf_data = '0;
    logic [C*16-1:0]    w_out;
    logic [C-1:0]       accept_w_out;
    logic [R*16-1:0]    x_out;
    logic [R-1:0]       valid_out;
    logic [R-1:0]       switch_out;
    logic               busy;
    logic               done;

    logic [15:0]        wm [R*C];
    logic [15:0]        xm [MV*R];
    int                 n_cmp = 0;
    int                 n_err = 0;

    systolic_feeder #(.ROWS(R), .COLS(C), .MAX_VEC(MV)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_vec_i(num_vec),
        .wbuf_we_i(wbuf_we), .wbuf_addr_i(wbuf_addr), .wbuf_data_i(wbuf_data),
        .xbuf_we_i(xbuf_we), .xbuf_addr_i(xbuf_addr), .xbuf_data_i(xbuf_data),
        .w_out_o(w_out), .accept_w_out_o(accept_w_out), .x_out_o(x_out),
        .valid_out_o(valid_out), .switch_out_o(switch_out), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".w_out"}, 64'(w_out), 64'd0);
        check({tag, ".accept"}, 64'(accept_w_out), 64'd0);
        check({tag, ".x_out"}, 64'(x_out), 64'd0);
        check({tag, ".valid"}, 64'(valid_out), 64'd0);
        check({tag, ".switch"}, 64'(switch_out), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
    endtask

    task automatic write_w(input int addr, input logic [15:0] data);
        wbuf_we = 1'b1; wbuf_addr = WAW'(addr); wbuf_data = data;
        step();
        wbuf_we = 1'b0;
        wm[addr] = data;
    endtask

    task automatic write_x(input int addr, input logic [15:0] data);
        xbuf_we = 1'b1; xbuf_addr = XAW'(addr); xbuf_data = data;
        step();
        xbuf_we = 1'b0;
        xm[addr] = data;
    endtask

    // Expected waveform is scattered into per-cycle tables straight from the element schedule.
    task automatic run(input int nv, input int rst_at, input bit poke, input bit chain);
        logic [C*16-1:0] ew [64];
        logic [C-1:0]    ea [64];
        logic [R*16-1:0] ex [64];
        logic [R-1:0]    ev [64];
        logic [R-1:0]    es [64];
        logic            eb [64];
        logic            ed [64];
        int last_v, dn, lim;
        last_v = 2 * R + nv - 1;
        dn     = last_v + R + C;
        lim    = chain ? dn + 1 : dn + 3;
        for (int n = 0; n < 64; n++) begin
            ew[n] = '0; ea[n] = '0; ex[n] = '0; ev[n] = '0; es[n] = '0; eb[n] = 1'b0; ed[n] = 1'b0;
        end
        for (int k = 0; k < R; k++) begin
            ea[k+1] = '1;
            for (int c = 0; c < C; c++) ew[k+1][c*16 +: 16] = wm[(R - 1 - k) * C + c];
        end
        for (int jj = 0; jj < nv; jj++)
            for (int r = 0; r < R; r++) begin
                ex[R+1+jj+r][r*16 +: 16] = xm[jj * R + r];
                ev[R+1+jj+r][r] = 1'b1;
                if (jj == 0) es[R+1+r][r] = 1'b1;
            end
        for (int n = 1; n <= dn; n++) eb[n] = 1'b1;
        ed[dn] = 1'b1;
        if (rst_at >= 0)
            for (int n = rst_at + 1; n < 64; n++) begin
                ew[n] = '0; ea[n] = '0; ex[n] = '0; ev[n] = '0; es[n] = '0; eb[n] = 1'b0; ed[n] = 1'b0;
            end
        start = 1'b1;
        num_vec = NVW'(nv);
        for (int n = 1; n <= lim; n++) begin
            step();
            start = 1'b0; rst = 1'b0; wbuf_we = 1'b0; xbuf_we = 1'b0;
            num_vec = NVW'($urandom_range(0, 15));
            check($sformatf("w_out@%0d", n), 64'(w_out), 64'(ew[n]));
            check($sformatf("accept@%0d", n), 64'(accept_w_out), 64'(ea[n]));
            check($sformatf("x_out@%0d", n), 64'(x_out), 64'(ex[n]));
            check($sformatf("valid@%0d", n), 64'(valid_out), 64'(ev[n]));
            check($sformatf("switch@%0d", n), 64'(switch_out), 64'(es[n]));
            check($sformatf("busy@%0d", n), 64'(busy), 64'(eb[n]));
            check($sformatf("done@%0d", n), 64'(done), 64'(ed[n]));
            if (poke && n == 5) begin
                start = 1'b1; num_vec = NVW'(nv);
                wbuf_we = 1'b1; wbuf_addr = WAW'($urandom_range(0, R * C - 1)); wbuf_data = 16'($urandom);
                xbuf_we = 1'b1; xbuf_addr = XAW'($urandom_range(0, MV * R - 1)); xbuf_data = 16'($urandom);
            end
            if (n == rst_at) rst = 1'b1;
        end
    endtask

    task automatic bad_start(input int nv);
        start = 1'b1;
        num_vec = NVW'(nv);
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_idle($sformatf("bad%0d@%0d", nv, i + 1));
            step();
        end
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        for (int a = 0; a < R * C; a++) write_w(a, 16'(a + 1));
        for (int a = 0; a < 3 * R; a++) write_x(a, 16'(a + 5));
        for (int a = 3 * R; a < MV * R; a++) write_x(a, 16'($urandom));
        run(3, -1, 1'b1, 1'b1);
        run(3, -1, 1'b0, 1'b0);
        run(3, 4, 1'b0, 1'b0);
        run(3, -1, 1'b0, 1'b0);
        bad_start(0);
        bad_start(MV + 1);
        bad_start(15);
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < R * C; a++) write_w(a, 16'($urandom));
            for (int a = 0; a < MV * R; a++) write_x(a, 16'($urandom));
            run($urandom_range(1, MV), (it == 5) ? $urandom_range(1, 8) : -1, it[0], it[1]);
        end
        run(MV, -1, 1'b0, 1'b0);
        run(1, -1, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001: Parameter ROWS, default 2, number of PE rows fed on the west edge.
REQ-002: Parameter COLS, default 2, number of PE columns fed on the north edge.
REQ-003: Parameter MAX_VEC, default 8, input-vector buffer depth in vectors.
REQ-004: clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-005: rst  in  1  synchronous, active-high reset.
REQ-006: start  in  1  run request; sampled only in IDLE.
REQ-007: num_vec  in  $clog2(MAX_VEC+1)  vector count; sampled with start.
REQ-008: wbuf_we, wbuf_addr (ROWS*COLS entries), wbuf_data[15:0]  in  weight buffer write port; W[r][c] at addr r*COLS+c.
REQ-009: xbuf_we, xbuf_addr (MAX_VEC*ROWS entries), xbuf_data[15:0]  in  input buffer write port; X[j][r] at addr j*ROWS+r.
REQ-010: w_out  out  COLS*16  signed weight to top PE of column c (slice c).
REQ-011: accept_w_out  out  COLS  weight-accept per column.
REQ-012: x_out  out  ROWS*16  signed activation to west PE of row r (slice r).
REQ-013: valid_out  out  ROWS  activation valid per row.
REQ-014: switch_out  out  ROWS  active-weight switch per row.
REQ-015: busy  out  1  high in any state other than IDLE.
REQ-016: done  out  1  one-cycle completion pulse.

Function
REQ-017: States SHALL be IDLE, LOAD_W, STREAM, DRAIN; all outputs registered.
REQ-018: IDLE->LOAD_W when start=1 and num_vec in 1..MAX_VEC; start with num_vec=0 or >MAX_VEC SHALL be ignored (stay IDLE, no done).
REQ-019: With start sampled at cycle 0, accept_w_out SHALL be all-ones in cycles 1..ROWS, w_out slice c in cycle k SHALL be W[ROWS-1-k'][c] where k'=k-1 (bottom row first).
REQ-020: Outside LOAD_W, accept_w_out SHALL be 0 and w_out SHALL be 0.
REQ-021: Element X[j][r] SHALL appear on x_out slice r with valid_out[r]=1 in cycle ROWS+1+j+r (row r skewed by r cycles).
REQ-022: switch_out[r] SHALL be 1 only in cycle ROWS+1+r, coincident with vector 0 on row r.
REQ-023: Any row with no element scheduled in a cycle SHALL drive x_out slice 0, valid_out 0.
REQ-024: Last valid cycle L=2*ROWS+num_vec-1; DRAIN SHALL follow, and done SHALL pulse exactly in cycle L+ROWS+COLS, returning to IDLE that same cycle (busy 0 from cycle L+ROWS+COLS+1).
REQ-025: start while busy SHALL be ignored; a new run may start in the cycle after done.
REQ-026: Buffer writes SHALL be ignored while busy; writes in IDLE take effect for the next run.
REQ-027: Data SHALL pass unmodified (no arithmetic); num_vec SHALL be latched, later changes ignored for the run.

Reset
REQ-028: rst=1 SHALL force IDLE and zero w_out, accept_w_out, x_out, valid_out, switch_out, busy, done on the next edge, including mid-run (run aborted, no done).
REQ-029: Buffer contents SHALL be retained through reset.

Verification
REQ-030: ROWS=COLS=2, W={1,2;3,4}, start cycle 0 -> cycle 1 w_out={3,4}, cycle 2 w_out={1,2}, accept_w_out=2'b11 both cycles only.
REQ-031: X={{5,6},{7,8},{9,10}}, num_vec=3 -> row0 valid cycles 3,4,5 with 5,7,9; row1 cycles 4,5,6 with 6,8,10; switch_out[0] cycle 3, [1] cycle 4; done cycle 10.
REQ-032: start with num_vec=0 -> busy stays 0, all outputs 0, no done.
REQ-033: rst asserted cycle 4 of REQ-031 run -> cycle 5 all outputs 0, busy 0, no done; restart reuses retained buffers with identical output.
REQ-034: start pulsed in cycle 5 and buffer write during run -> ignored; back-to-back start in cycle 11 -> identical second run.
